// File: rtl/mips_fetch_pkg.sv
// Shared constants, slot record and pointer arithmetic for the MIPS fetch front end.
// Slot fields are sized for the widest supported core (ADDR_W, INSTR_W <= 32).
package mips_fetch_pkg;

  localparam int unsigned       SLOT_W     = 32;
  localparam logic [SLOT_W-1:0] INSTR_HALT = 32'h0;
  localparam int unsigned       PC_STEP    = 4;

  typedef struct packed {
    logic [SLOT_W-1:0] pc;
    logic [SLOT_W-1:0] data;
    logic              filled;
  } fetch_slot_t;

  // Difference of two wrap-bit pointers, reduced modulo 2^ptr_w.
  function automatic int unsigned ptr_diff(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned ptr_w);
    int unsigned mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/fetch_slot_queue.sv
// In-order slot storage with tail (allocate), fill (response) and head (dequeue)
// pointers; each pointer carries a wrap bit so full and empty are distinct.
module fetch_slot_queue #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alloc,
  input  logic [ADDR_W-1:0]          alloc_pc,
  input  logic                       fill,
  input  logic [INSTR_W-1:0]         fill_data,
  input  logic                       deq,
  output logic                       head_filled,
  output logic [ADDR_W-1:0]          head_pc,
  output logic [INSTR_W-1:0]         head_data,
  output logic                       credit,
  output logic [$clog2(DEPTH):0]     pending,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  import mips_fetch_pkg::*;

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] tail, fill_ptr, head;
  logic [IDX_W-1:0] tail_idx, fill_idx, head_idx;
  fetch_slot_t      slots [DEPTH];

  assign tail_idx = tail[IDX_W-1:0];
  assign fill_idx = fill_ptr[IDX_W-1:0];
  assign head_idx = head[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail     <= '0;
      fill_ptr <= '0;
      head     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) slots[IDX_W'(i)] <= '0;
    end else if (flush) begin
      tail     <= '0;
      fill_ptr <= '0;
      head     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) slots[IDX_W'(i)].filled <= 1'b0;
    end else begin
      // alloc, fill and deq never address the same slot in one cycle
      if (alloc) begin
        slots[tail_idx].pc     <= SLOT_W'(alloc_pc);
        slots[tail_idx].filled <= 1'b0;
        tail                   <= tail + PTR_W'(1);
      end
      if (fill) begin
        slots[fill_idx].data   <= SLOT_W'(fill_data);
        slots[fill_idx].filled <= 1'b1;
        fill_ptr               <= fill_ptr + PTR_W'(1);
      end
      if (deq) begin
        slots[head_idx].filled <= 1'b0;
        head                   <= head + PTR_W'(1);
      end
    end
  end

  assign head_filled = slots[head_idx].filled;
  assign head_pc     = slots[head_idx].pc[ADDR_W-1:0];
  assign head_data   = slots[head_idx].data[INSTR_W-1:0];
  assign occupancy   = OCC_W'(ptr_diff(32'(tail), 32'(head), PTR_W));
  assign pending     = PTR_W'(ptr_diff(32'(tail), 32'(fill_ptr), PTR_W));
  assign credit      = occupancy < OCC_W'(DEPTH);

endmodule

// File: rtl/mips_fetch_unit.sv
// Decoupled instruction fetcher: pipelined requests to a variable-latency imem,
// in-order buffering with PCs, redirect flush with stale-response discard, halt.
module mips_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [ADDR_W-1:0]          imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [INSTR_W-1:0]         imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [INSTR_W-1:0]         inst_data,
  output logic [ADDR_W-1:0]          inst_pc,
  output logic                       halt,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  import mips_fetch_pkg::*;

  localparam int unsigned       PTR_W     = $clog2(DEPTH) + 1;
  localparam int unsigned       DISC_W    = PTR_W + 2;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [DISC_W-1:0]  discard;
  logic [DISC_W-1:0]  owed;
  logic [PTR_W-1:0]   pending;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_data;
  logic               head_filled, head_is_halt, credit;
  logic               req_fire, rsp_fill, rsp_drop, deq, discard_idle;

  assign head_is_halt   = head_data == INSTR_HALT[INSTR_W-1:0];
  assign discard_idle   = discard == '0;
  assign imem_req_valid = credit && !halt && !redirect_valid && !rst;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fill       = imem_rsp_valid && !redirect_valid && discard_idle && (pending != '0);
  assign rsp_drop       = imem_rsp_valid && !redirect_valid && !discard_idle;
  assign inst_valid     = head_filled && !halt && !head_is_halt;
  assign deq            = inst_valid && inst_ready && !redirect_valid;
  assign inst_data      = head_data;
  assign inst_pc        = head_pc;
  // Everything still owed by memory; folding in the old discard keeps back-to-back redirects safe.
  assign owed           = discard + DISC_W'(pending);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      halt     <= 1'b0;
      discard  <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & WORD_MASK;
      halt     <= 1'b0;
      discard  <= (imem_rsp_valid && owed != '0) ? owed - DISC_W'(1) : owed;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      if (head_filled && head_is_halt) halt <= 1'b1;
      if (rsp_drop) discard <= discard - DISC_W'(1);
    end
  end

  fetch_slot_queue #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect_valid),
    .alloc       (req_fire),
    .alloc_pc    (fetch_pc),
    .fill        (rsp_fill),
    .fill_data   (imem_rsp_data),
    .deq         (deq),
    .head_filled (head_filled),
    .head_pc     (head_pc),
    .head_data   (head_data),
    .credit      (credit),
    .pending     (pending),
    .occupancy   (occupancy)
  );

  // A response with nothing pending and nothing to discard breaks the memory protocol.
  rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && discard_idle && pending == '0));

endmodule
